// File: rtl/snn_window_ctrl.sv
// -----------------------------------------------------------------------------
// snn_window_ctrl
//
// Inference sequencer for the 8-3-10 spiking network. A start request clears
// the LIF neurons and spike counters, lets the network evolve for WINDOW
// timesteps, then walks the NUM_CLASSES spike counters one per cycle through
// an external select mux. It tracks the running argmax and reports class,
// count and tie flag over a valid/ready handshake.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        classification request (sampled only in IDLE)
//   abort_i        cancel an in-flight window (CLEAR/RUN/SCAN only)
//   busy_o         high whenever the sequencer is not IDLE
//   net_clear_o    one-cycle clear pulse to neurons and spike counters
//   net_en_o       timestep enable to neurons and spike counters
//   count_sel_o    counter index for the external count mux (0 outside SCAN)
//   count_i        spike count selected by count_sel_o (same cycle)
//   result_valid_o result available
//   result_ready_i consumer accepts result
//   class_o        argmax class index (lowest index wins on a tie)
//   max_count_o    spike count of class_o
//   tie_o          more than one class holds max_count_o
// -----------------------------------------------------------------------------
module snn_window_ctrl #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH_P     = 8,
    parameter int WINDOW      = 64,
    parameter int WIN_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               net_clear_o,
    output logic               net_en_o,
    output logic [3:0]         count_sel_o,
    input  logic [WIDTH_P-1:0] count_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [3:0]         class_o,
    output logic [WIDTH_P-1:0] max_count_o,
    output logic               tie_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [WIN_W-1:0] TS_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_CLASSES - 1);

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   ts_q, ts_d;
    logic [3:0]         idx_q, idx_d;
    logic [WIDTH_P-1:0] max_q, max_d;
    logic [3:0]         class_q, class_d;
    logic               tie_q, tie_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ts_q    <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            class_q <= '0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            class_q <= class_d;
            tie_q   <= tie_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // abort has no meaning here, so start always wins
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = abort_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort_i)              state_d = S_IDLE;
                else if (ts_q == TS_LAST) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (abort_i)                state_d = S_IDLE;
                else if (idx_q == IDX_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (result_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Timestep counter, scan index and running argmax
    // ------------------------------------------------------------------
    always_comb begin
        ts_d    = ts_q;
        idx_d   = idx_q;
        max_d   = max_q;
        class_d = class_q;
        tie_d   = tie_q;
        case (state_q)
            S_CLEAR: begin
                ts_d = '0;
            end
            S_RUN: begin
                idx_d = '0;
                // restart the counter on the last step so it never has to
                // represent WINDOW itself
                if (ts_q == TS_LAST) ts_d = '0;
                else                 ts_d = ts_q + WIN_W'(1);
            end
            S_SCAN: begin
                // an abort edge leaves the partial result untouched
                if (!abort_i) begin
                    idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
                    if (idx_q == 4'd0) begin
                        max_d   = count_i;
                        class_d = 4'd0;
                        tie_d   = 1'b0;
                    end else if (count_i > max_q) begin
                        max_d   = count_i;
                        class_d = idx_q;
                        tie_d   = 1'b0;
                    end else if (count_i == max_q) begin
                        // keep the earlier class: lowest index wins
                        tie_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only
    // ------------------------------------------------------------------
    always_comb begin
        busy_o         = (state_q != S_IDLE);
        net_clear_o    = (state_q == S_CLEAR);
        net_en_o       = (state_q == S_RUN);
        result_valid_o = (state_q == S_DONE);
        count_sel_o    = (state_q == S_SCAN) ? idx_q : 4'd0;
        class_o        = class_q;
        max_count_o    = max_q;
        tie_o          = tie_q;
    end

endmodule

// File: tb/tb_snn_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_window_ctrl
//
// Self-checking bench for snn_window_ctrl (WINDOW=4, NUM_CLASSES=10). The
// external count mux is modelled by an array indexed by count_sel_o. Expected
// results come from a plain argmax over that array. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_snn_window_ctrl;

    localparam int NUM_CLASSES = 10;
    localparam int WIDTH_P     = 8;
    localparam int WINDOW      = 4;
    localparam int WIN_W       = 8;
    localparam int LAT         = 1 + WINDOW + NUM_CLASSES;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_i;
    logic               abort_i;
    logic               busy_o;
    logic               net_clear_o;
    logic               net_en_o;
    logic [3:0]         count_sel_o;
    logic [WIDTH_P-1:0] count_i;
    logic               result_valid_o;
    logic               result_ready_i;
    logic [3:0]         class_o;
    logic [WIDTH_P-1:0] max_count_o;
    logic               tie_o;

    logic [WIDTH_P-1:0] counts [16];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    always_comb count_i = counts[count_sel_o];

    snn_window_ctrl #(
        .NUM_CLASSES(NUM_CLASSES),
        .WIDTH_P    (WIDTH_P),
        .WINDOW     (WINDOW),
        .WIN_W      (WIN_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .net_clear_o   (net_clear_o),
        .net_en_o      (net_en_o),
        .count_sel_o   (count_sel_o),
        .count_i       (count_i),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .class_o       (class_o),
        .max_count_o   (max_count_o),
        .tie_o         (tie_o)
    );

    // Reference: argmax with lowest index winning, tie when the max occurs twice+
    function automatic void ref_result(output int cls, output int mx, output bit tie);
        int n;
        n   = 0;
        mx  = -1;
        cls = 0;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (int'(counts[i]) > mx) begin
                mx  = int'(counts[i]);
                cls = i;
            end
        for (int i = 0; i < NUM_CLASSES; i++)
            if (int'(counts[i]) == mx) n++;
        tie = (n > 1);
    endfunction

    // Pulse start at a falling edge and watch the window until valid (bounded).
    // valid_at is the cycle index after the start edge (CLEAR = 0), -1 on timeout.
    task automatic run_window(output int clr_n, output int en_n,
                              output int valid_at, output int sel_err);
        int scan_n;
        scan_n   = 0;
        clr_n    = 0;
        en_n     = 0;
        valid_at = -1;
        sel_err  = 0;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        for (int c = 0; c < LAT + 20; c++) begin
            clr_n += int'(net_clear_o);
            en_n  += int'(net_en_o);
            if (busy_o && !net_clear_o && !net_en_o && !result_valid_o) begin
                if (count_sel_o != 4'(scan_n)) sel_err++;
                scan_n++;
            end else if (count_sel_o != 4'd0) begin
                sel_err++;
            end
            if (result_valid_o) begin
                valid_at = c;
                if (scan_n != NUM_CLASSES) sel_err++;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        start_i        = 1'b0;
        abort_i        = 1'b0;
        result_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) counts[i] = '0;
        #1;
        total_cnt++;
        if ({busy_o, net_clear_o, net_en_o, count_sel_o, result_valid_o, class_o, max_count_o, tie_o} !== '0)
            $display("FAIL reset_outputs: got busy=%b clr=%b en=%b sel=%0d valid=%b class=%0d max=%0d tie=%b, want all 0",
                     busy_o, net_clear_o, net_en_o, count_sel_o, result_valid_o, class_o, max_count_o, tie_o);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            total_cnt++;
            if ({busy_o, net_en_o, net_clear_o, result_valid_o, class_o} !== '0)
                $display("FAIL idle_cycle%0d: got busy=%b en=%b clr=%b valid=%b class=%0d, want 0",
                         i, busy_o, net_en_o, net_clear_o, result_valid_o, class_o);
            else pass_cnt++;
            @(negedge clk);
        end
        $display("idle: 20 cycles checked");
    endtask

    // Directed count vectors with expected results written out by hand
    task automatic test_directed();
        int vec [3][10] = '{'{3, 9, 2, 0, 0, 0, 0, 0, 0, 1},
                            '{5, 7, 7, 0, 0, 0, 0, 0, 0, 7},
                            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        int exp_cls [3] = '{1, 1, 0};
        int exp_max [3] = '{9, 7, 0};
        bit exp_tie [3] = '{1'b0, 1'b1, 1'b1};
        int clr_n, en_n, valid_at, sel_err;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NUM_CLASSES; i++) counts[i] = WIDTH_P'(vec[t][i]);
            run_window(clr_n, en_n, valid_at, sel_err);
            total_cnt++;
            if (clr_n != 1 || en_n != WINDOW || valid_at != LAT || sel_err != 0)
                $display("FAIL directed%0d_timing: got clr=%0d en=%0d valid_at=%0d sel_err=%0d, want 1 %0d %0d 0",
                         t, clr_n, en_n, valid_at, sel_err, WINDOW, LAT);
            else pass_cnt++;
            total_cnt++;
            if (int'(class_o) != exp_cls[t] || int'(max_count_o) != exp_max[t] || tie_o !== exp_tie[t])
                $display("FAIL directed%0d_result: got class=%0d max=%0d tie=%b, want %0d %0d %b",
                         t, class_o, max_count_o, tie_o, exp_cls[t], exp_max[t], exp_tie[t]);
            else pass_cnt++;
            result_ready_i = 1'b1;
            @(negedge clk);
            result_ready_i = 1'b0;
            total_cnt++;
            if (busy_o !== 1'b0 || result_valid_o !== 1'b0)
                $display("FAIL directed%0d_handshake: got busy=%b valid=%b, want 0 0", t, busy_o, result_valid_o);
            else pass_cnt++;
            $display("directed%0d: class=%0d max=%0d tie=%b", t, class_o, max_count_o, tie_o);
        end
    endtask

    task automatic test_random();
        int clr_n, en_n, valid_at, sel_err, e_cls, e_max;
        bit e_tie;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                counts[i] = (t % 2 == 0) ? WIDTH_P'($urandom_range(0, 5)) : WIDTH_P'($urandom);
            ref_result(e_cls, e_max, e_tie);
            // ready held high outside DONE must have no effect
            result_ready_i = (t % 3 == 0);
            run_window(clr_n, en_n, valid_at, sel_err);
            total_cnt++;
            if (clr_n != 1 || en_n != WINDOW || valid_at != LAT || sel_err != 0)
                $display("FAIL random%0d_timing: got clr=%0d en=%0d valid_at=%0d sel_err=%0d, want 1 %0d %0d 0",
                         t, clr_n, en_n, valid_at, sel_err, WINDOW, LAT);
            else pass_cnt++;
            total_cnt++;
            if (int'(class_o) != e_cls || int'(max_count_o) != e_max || tie_o !== e_tie)
                $display("FAIL random%0d_result: got class=%0d max=%0d tie=%b, want %0d %0d %b",
                         t, class_o, max_count_o, tie_o, e_cls, e_max, e_tie);
            else pass_cnt++;
            result_ready_i = 1'b1;
            @(negedge clk);
            result_ready_i = 1'b0;
            total_cnt++;
            if (busy_o !== 1'b0 || result_valid_o !== 1'b0)
                $display("FAIL random%0d_handshake: got busy=%b valid=%b, want 0 0", t, busy_o, result_valid_o);
            else pass_cnt++;
            $display("random%0d: class=%0d max=%0d tie=%b", t, class_o, max_count_o, tie_o);
        end
    endtask

    task automatic test_backpressure();
        int clr_n, en_n, valid_at, sel_err, e_cls, e_max;
        bit e_tie;
        for (int i = 0; i < NUM_CLASSES; i++) counts[i] = WIDTH_P'($urandom_range(0, 255));
        counts[6] = 8'd255;
        ref_result(e_cls, e_max, e_tie);
        run_window(clr_n, en_n, valid_at, sel_err);
        total_cnt++;
        if (valid_at != LAT)
            $display("FAIL backpressure_latency: got %0d, want %0d", valid_at, LAT);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            start_i = (i % 3 == 1);
            @(negedge clk);
            total_cnt++;
            if (result_valid_o !== 1'b1 || busy_o !== 1'b1 || int'(class_o) != e_cls ||
                int'(max_count_o) != e_max || tie_o !== e_tie || net_clear_o !== 1'b0)
                $display("FAIL backpressure_hold%0d: got valid=%b busy=%b class=%0d max=%0d tie=%b clr=%b, want 1 1 %0d %0d %b 0",
                         i, result_valid_o, busy_o, class_o, max_count_o, tie_o, net_clear_o, e_cls, e_max, e_tie);
            else pass_cnt++;
        end
        // start in the completing cycle is ignored
        start_i        = 1'b1;
        result_ready_i = 1'b1;
        @(negedge clk);
        start_i        = 1'b0;
        result_ready_i = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b0 || result_valid_o !== 1'b0)
            $display("FAIL backpressure_release: got busy=%b valid=%b, want 0 0", busy_o, result_valid_o);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy_o !== 1'b0 || net_clear_o !== 1'b0)
            $display("FAIL backpressure_start_ignored: got busy=%b clr=%b, want 0 0", busy_o, net_clear_o);
        else pass_cnt++;
        $display("backpressure: class=%0d max=%0d tie=%b", class_o, max_count_o, tie_o);
    endtask

    task automatic test_abort();
        int en_n, clr_n, valid_at, sel_err, e_cls, e_max, seen_valid;
        bit e_tie;
        en_n       = 0;
        seen_valid = 0;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        // cycle 0 is CLEAR, cycles 1 and 2 are the first two RUN cycles
        for (int c = 0; c < 3; c++) begin
            en_n += int'(net_en_o);
            if (c == 2) abort_i = 1'b1;
            @(negedge clk);
        end
        abort_i = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b0 || net_en_o !== 1'b0 || en_n != 2)
            $display("FAIL abort_idle: got busy=%b en=%b en_cycles=%0d, want 0 0 2", busy_o, net_en_o, en_n);
        else pass_cnt++;
        for (int c = 0; c < LAT + 4; c++) begin
            seen_valid += int'(result_valid_o) + int'(busy_o);
            @(negedge clk);
        end
        total_cnt++;
        if (seen_valid != 0)
            $display("FAIL abort_no_valid: got %0d busy/valid cycles, want 0", seen_valid);
        else pass_cnt++;
        for (int i = 0; i < NUM_CLASSES; i++) counts[i] = WIDTH_P'($urandom_range(0, 20));
        ref_result(e_cls, e_max, e_tie);
        run_window(clr_n, en_n, valid_at, sel_err);
        total_cnt++;
        if (clr_n != 1 || en_n != WINDOW || valid_at != LAT || sel_err != 0 ||
            int'(class_o) != e_cls || int'(max_count_o) != e_max || tie_o !== e_tie)
            $display("FAIL abort_rerun: got clr=%0d en=%0d valid_at=%0d sel_err=%0d class=%0d max=%0d tie=%b, want 1 %0d %0d 0 %0d %0d %b",
                     clr_n, en_n, valid_at, sel_err, class_o, max_count_o, tie_o, WINDOW, LAT, e_cls, e_max, e_tie);
        else pass_cnt++;
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
        $display("abort: rerun class=%0d max=%0d tie=%b", class_o, max_count_o, tie_o);
    endtask

    task automatic test_async_reset();
        int clr_n, en_n, valid_at, sel_err, e_cls, e_max;
        bit e_tie;
        for (int i = 0; i < NUM_CLASSES; i++) counts[i] = WIDTH_P'(i + 1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        // SCAN begins at cycle 1+WINDOW; index 5 is five cycles later
        repeat (1 + WINDOW + 5) @(negedge clk);
        total_cnt++;
        if (count_sel_o !== 4'd5)
            $display("FAIL async_reset_scan_idx: got %0d, want 5", count_sel_o);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy_o, net_clear_o, net_en_o, count_sel_o, result_valid_o, class_o, max_count_o, tie_o} !== '0)
            $display("FAIL async_reset_outputs: got busy=%b clr=%b en=%b sel=%0d valid=%b class=%0d max=%0d tie=%b, want all 0",
                     busy_o, net_clear_o, net_en_o, count_sel_o, result_valid_o, class_o, max_count_o, tie_o);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_CLASSES; i++) counts[i] = WIDTH_P'($urandom_range(0, 255));
        ref_result(e_cls, e_max, e_tie);
        run_window(clr_n, en_n, valid_at, sel_err);
        total_cnt++;
        if (clr_n != 1 || en_n != WINDOW || valid_at != LAT || sel_err != 0 ||
            int'(class_o) != e_cls || int'(max_count_o) != e_max || tie_o !== e_tie)
            $display("FAIL async_reset_rerun: got clr=%0d en=%0d valid_at=%0d sel_err=%0d class=%0d max=%0d tie=%b, want 1 %0d %0d 0 %0d %0d %b",
                     clr_n, en_n, valid_at, sel_err, class_o, max_count_o, tie_o, WINDOW, LAT, e_cls, e_max, e_tie);
        else pass_cnt++;
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
        $display("async_reset: rerun class=%0d max=%0d tie=%b", class_o, max_count_o, tie_o);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_directed();
        test_random();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/snn_window_ctrl.md
Name: snn_window_ctrl

Overview:
Inference sequencer for the 8-3-10 spiking network. On a start request it clears the LIF neurons and spike counters, enables network evolution for a fixed window of timesteps, then scans the NUM_CLASSES spike counts one per cycle through a select mux. It reports the argmax class, its count and a tie flag over a valid/ready handshake, so the pads carry a class ID instead of one raw counter.

Parameters:
NUM_CLASSES, 10, number of output neurons/counters scanned (2..16)
WIDTH_P, 8, spike count width
WINDOW, 64, timesteps per classification window (1..255; 0 illegal)
WIN_W, 8, width of timestep counter (must hold WINDOW-1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  request a classification; sampled only in IDLE
abort_i  in  1  cancel an in-flight window; effective in CLEAR/RUN/SCAN
busy_o  out  1  high in every state except IDLE
net_clear_o  out  1  one-cycle synchronous clear to LIF neurons and spike_counter
net_en_o  out  1  timestep enable to LIF neurons and spike_counter
count_sel_o  out  4  counter index driven to the external count mux
count_i  in  WIDTH_P  spike count selected by count_sel_o (combinational, same cycle)
result_valid_o  out  1  result available
result_ready_i  in  1  consumer accepts result
class_o  out  4  argmax class index
max_count_o  out  WIDTH_P  spike count of class_o
tie_o  out  1  more than one class holds max_count_o

Behaviour:
- Reset (async, rst_ni=0): state IDLE. All outputs 0, including class_o, max_count_o and tie_o. Timestep counter and scan index are 0.
- FSM states: IDLE, CLEAR, RUN, SCAN, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE: start_i=1 -> CLEAR. Otherwise stay.
- CLEAR: net_clear_o=1 for exactly this one cycle; timestep counter <= 0; -> RUN.
- RUN: net_en_o=1 every cycle; counter increments.
  - When counter==WINDOW-1 -> SCAN, so net_en_o is high for exactly WINDOW cycles.
  - scan index <= 0.
- SCAN: count_sel_o = scan index; count_i is sampled on each edge.
  - idx 0: max<=count_i, class<=0, tie<=0.
  - idx>0 with count_i>max: max<=count_i, class<=idx, tie<=0.
  - idx>0 with count_i==max: tie<=1; class unchanged, so the lowest index wins.
  - count_i<max: no change.
  - After idx==NUM_CLASSES-1 is sampled -> DONE.
  - SCAN lasts exactly NUM_CLASSES cycles.
- Result registers: class_o, max_count_o and tie_o update only during SCAN. They hold their value through DONE and afterwards until the next SCAN.
- DONE: result_valid_o=1 and held stable until result_ready_i=1.
  - On the valid&ready edge -> IDLE; valid drops the next cycle.
  - result_ready_i outside DONE is ignored.
- Latency: start sampled at edge E0. CLEAR begins at E0, RUN at E0+1, SCAN at E0+1+WINDOW, DONE at E0+1+WINDOW+NUM_CLASSES.
- start_i while busy_o=1 is ignored, not queued. A start in the cycle valid&ready completes is also ignored; it is sampled from the IDLE cycle onward.
- abort_i in CLEAR/RUN/SCAN -> IDLE next edge.
  - net_en_o drops that edge; no result_valid_o is raised.
  - Result registers keep whatever SCAN wrote (partial results are allowed and are not flagged valid).
  - abort_i in IDLE or DONE is ignored.
- abort_i and start_i together in IDLE -> start wins (abort has no effect in IDLE).
- count_sel_o is 0 outside SCAN.
- Arithmetic: the compare is unsigned WIDTH_P-bit; max_count_o may legitimately be 0 (all counts zero -> class 0, tie_o=1).
- Reset mid-operation: returns to IDLE immediately with all outputs 0; no handshake completes.

Test Plan:
- Reset then idle (WINDOW=4): hold start_i=0 for 20 cycles -> busy_o, net_en_o, net_clear_o and result_valid_o stay 0; class_o=0.
- Nominal run (WINDOW=4, counts [3,9,2,0,0,0,0,0,0,1]): start pulse -> net_clear_o high 1 cycle, net_en_o high exactly 4 cycles, count_sel_o steps 0..9, valid at E0+15; class_o=1, max_count_o=9, tie_o=0.
- Tie: counts [5,7,7,0,...,7] -> class_o=1, max_count_o=7, tie_o=1. All-zero counts -> class_o=0, max_count_o=0, tie_o=1.
- Backpressure: hold result_ready_i=0 for 10 cycles in DONE -> valid and outputs stable; start_i pulses ignored. Ready=1 -> IDLE next cycle, busy_o=0.
- Abort: assert abort_i on the 2nd RUN cycle -> IDLE next edge, net_en_o was high for exactly 2 cycles, no valid. A following start produces a full, correct window.
- Async reset mid-SCAN (idx 5): rst_ni low between clock edges -> all outputs 0 immediately. After release, start gives a normal result at E0+15.
